// File: rtl/enc_pkg.sv
// enc_pkg
// Shared definitions for the encryption-core arbiter slice.
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   ENC_DATA_W   - cipher block width (64)
//   ENC_KEY_W    - cipher key width (128)
package enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   localparam int ENC_DATA_W = 64;
   localparam int ENC_KEY_W  = 128;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after ptr, wrapping around past NUM_REQ-1 back to 0.
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   IDW      highest-priority index for this pick
//   grant      out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out  IDW      index of the granted request
//   any_grant  out  1        at least one request is asserted
module rr_arbiter
   import enc_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_idx,
   output logic               any_grant
);

   // Walk the requests in priority order starting at ptr; the first hit wins
   // and later hits are masked by any_grant.
   always_comb begin
      logic [IDW-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NUM_REQ);
         if (!any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enc_core_arbiter.sv
// enc_core_arbiter
// Shares one block-encryption core among NUM_REQ requesters. Jobs are taken
// round-robin, issued to the core one at a time, and the ciphertext is returned
// tagged with the requester index on a single valid/ready response channel.
// Optional feature: define ENC_ARB_TIMEOUT_EN to add a WAIT-state watchdog that
// returns an error response (rsp_err=1, rsp_ciphertext=0) after TIMEOUT cycles.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester job handshake
//   req_plaintext/req_key          requester i at [i*W +: W]
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_ciphertext/rsp_err  response payload
//   core_start/core_plaintext/core_key    drive the core
//   core_ciphertext/core_done             core result
module enc_core_arbiter
   import enc_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = ENC_DATA_W,
   parameter  int KEY_W   = ENC_KEY_W,
   parameter  int TIMEOUT = 255,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_plaintext,
   input  logic [NUM_REQ*KEY_W-1:0]  req_key,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDW-1:0]            rsp_id,
   output logic [DATA_W-1:0]         rsp_ciphertext,
   output logic                      rsp_err,
   output logic                      core_start,
   output logic [DATA_W-1:0]         core_plaintext,
   output logic [KEY_W-1:0]          core_key,
   input  logic [DATA_W-1:0]         core_ciphertext,
   input  logic                      core_done
);

   arb_state_t         state, state_next;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     id_reg;
   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     grant_idx;
   logic               any_grant;
   logic               expired;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

`ifdef ENC_ARB_TIMEOUT_EN
   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Counter holds the number of WAIT cycles already spent; it is cleared
   // while issuing so the first WAIT cycle sees 0. Expiry fires on the
   // TIMEOUT-th WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign expired = (state == WAIT) && (wait_cnt == CNT_LAST);
   assign rsp_err = err_q;
`else
   assign expired = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // Next state and handshake strobes. Everything is held low while rst is
   // asserted so no requester or consumer sees a handshake that reset drops.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (any_grant) begin
                  req_ready  = grant;
                  state_next = ISSUE;
               end
            end
            ISSUE: begin
               core_start = 1'b1;
               state_next = WAIT;
            end
            WAIT: begin
               if (core_done || expired) begin
                  state_next = RESP;
               end
            end
            RESP: begin
               rsp_valid = 1'b1;
               if (rsp_ready) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register plus the job/response datapath. A core_done that arrives
   // outside WAIT is ignored because only the WAIT branch looks at it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ptr            <= '0;
         id_reg         <= '0;
         rsp_id         <= '0;
         rsp_ciphertext <= '0;
         core_plaintext <= '0;
         core_key       <= '0;
`ifdef ENC_ARB_TIMEOUT_EN
         err_q          <= 1'b0;
`endif
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (any_grant) begin
                  core_plaintext <= req_plaintext[int'(grant_idx)*DATA_W +: DATA_W];
                  core_key       <= req_key[int'(grant_idx)*KEY_W +: KEY_W];
                  id_reg         <= grant_idx;
               end
            end
            WAIT: begin
               if (core_done) begin
                  rsp_ciphertext <= core_ciphertext;
                  rsp_id         <= id_reg;
`ifdef ENC_ARB_TIMEOUT_EN
                  err_q          <= 1'b0;
               end else if (expired) begin
                  rsp_ciphertext <= '0;
                  rsp_id         <= id_reg;
                  err_q          <= 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  ptr <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + IDW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_enc_core_arbiter.sv
// tb_enc_core_arbiter
// Self-checking bench for enc_core_arbiter with a core stub that pulses
// core_done stub_lat cycles after core_start, ciphertext = plaintext ^ key[63:0].
// Covers reset values, round-robin order, backpressure, spurious done,
// reset mid-WAIT, a table of single-job vectors, randomized traffic against a
// behavioural model, and (with ENC_ARB_TIMEOUT_EN) the watchdog.
module tb_enc_core_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int KW = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_plaintext;
   logic [N*KW-1:0]   req_key;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_ciphertext;
   logic              rsp_err;
   logic              core_start;
   logic [DW-1:0]     core_plaintext;
   logic [KW-1:0]     core_key;
   logic [DW-1:0]     core_ciphertext;
   logic              core_done;

   logic [DW-1:0]     pt  [N];
   logic [KW-1:0]     key [N];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int stub_cnt   = 0;
   int stub_lat   = 10;
   bit stub_never = 1'b0;
   bit spur_en    = 1'b0;
   logic real_done;

   typedef struct {
      logic [N-1:0] valid;
      int           exp_id;
   } vec_t;
   vec_t tbl [8];

   enc_core_arbiter #(.NUM_REQ(N), .DATA_W(DW), .KEY_W(KW), .TIMEOUT(20)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_plaintext   (req_plaintext),
      .req_key         (req_key),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_ciphertext  (rsp_ciphertext),
      .rsp_err         (rsp_err),
      .core_start      (core_start),
      .core_plaintext  (core_plaintext),
      .core_key        (core_key),
      .core_ciphertext (core_ciphertext),
      .core_done       (core_done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pack per-requester job data onto the flat buses.
   always_comb begin
      req_plaintext = '0;
      req_key       = '0;
      for (int i = 0; i < N; i++) begin
         req_plaintext[i*DW +: DW] = pt[i];
         req_key[i*KW +: KW]       = key[i];
      end
   end

   // Core stub: counts cycles since core_start; optional spurious pulse
   // coincident with core_start (the arbiter is in ISSUE then).
   always @(posedge clk) begin
      if (core_start) stub_cnt <= 1;
      else if (stub_cnt != 0) stub_cnt <= stub_cnt + 1;
   end
   assign real_done       = (stub_cnt == stub_lat) && !stub_never;
   assign core_done       = real_done || (spur_en && core_start);
   assign core_ciphertext = real_done ? (core_plaintext ^ core_key[63:0])
                                      : 64'hbad0_bad0_bad0_bad0;

   initial begin
      #500000;
      $display("[TB] FAIL global_watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference round-robin rule: first pending index at or after ptr.
   function automatic int model_pick(input logic [N-1:0] pend, input int p);
      for (int k = 0; k < N; k++) if (pend[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic apply_stimulus_random_data();
      for (int i = 0; i < N; i++) begin
         pt[i]  = {$urandom, $urandom};
         key[i] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   // Entry at a negedge. Offers mask, returns granted index and grant cycle,
   // and leaves at the negedge after the handshake with req_valid dropped.
   task automatic wait_grant(input string name, input logic [N-1:0] mask,
                             output int g, output int t);
      int n = 0;
      g = -1;
      t = 0;
      req_valid = mask;
      #1;
      while (req_ready == '0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (req_ready == '0) begin
         check_output({name, "_grant_seen"}, 0, 1);
      end else begin
         check_output({name, "_ready_onehot_in_mask"},
                      $onehot(req_ready) && ((req_ready & ~mask) == '0), 1);
         g = onehot_idx(req_ready);
         t = cyc;
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   // Entry at a negedge; leaves at negedge+1 of the first rsp_valid cycle.
   task automatic wait_rsp(input string name, input int t_grant, output int lat);
      int n = 0;
      lat = -1;
      #1;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!rsp_valid) check_output({name, "_rsp_seen"}, 0, 1);
      else lat = cyc - t_grant;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_job(input string name, input logic [N-1:0] mask,
                          input int exp_id, input int exp_lat);
      int g, t, lat;
      logic [63:0] exp_ct;
      wait_grant(name, mask, g, t);
      check_output({name, "_grant_id"}, g, exp_id);
      exp_ct = pt[exp_id] ^ key[exp_id][63:0];
      wait_rsp(name, t, lat);
      check_output({name, "_latency"}, lat, exp_lat);
      check_output({name, "_rsp_id"}, rsp_id, exp_id);
      check_output({name, "_rsp_ct"}, rsp_ciphertext, exp_ct);
      check_output({name, "_rsp_err"}, rsp_err, 0);
      consume();
   endtask

   initial begin
      int g, t, lat, n, extra, overlap;
      int ids [5];
      int exp_ids [5] = '{0, 1, 2, 3, 0};
      logic [63:0] sv_ct;
      logic [1:0]  sv_id;
      logic [63:0] exp_ct;

      tbl[0] = '{valid: 4'b0100, exp_id: 2};
      tbl[1] = '{valid: 4'b0011, exp_id: 0};
      tbl[2] = '{valid: 4'b1001, exp_id: 3};
      tbl[3] = '{valid: 4'b1111, exp_id: 0};
      tbl[4] = '{valid: 4'b0001, exp_id: 0};
      tbl[5] = '{valid: 4'b1110, exp_id: 1};
      tbl[6] = '{valid: 4'b0010, exp_id: 1};
      tbl[7] = '{valid: 4'b1000, exp_id: 3};

      for (int i = 0; i < N; i++) begin
         pt[i]  = '0;
         key[i] = '0;
      end

      // Reset values
      apply_reset();
      #1;
      check_output("rst_req_ready", req_ready, 0);
      check_output("rst_rsp_valid", rsp_valid, 0);
      check_output("rst_core_start", core_start, 0);
      check_output("rst_rsp_id", rsp_id, 0);
      check_output("rst_rsp_ct", rsp_ciphertext, 0);
      check_output("rst_rsp_err", rsp_err, 0);
      check_output("rst_core_pt", core_plaintext, 0);
      check_output("rst_core_key", core_key, 0);
      @(negedge clk);

      // Round-robin with all requesters continuously valid
      apply_stimulus_random_data();
      n = 0;
      overlap = 0;
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 300 && n < 5; c++) begin
         #1;
         if ($countones(req_ready) > 1) overlap++;
         if (rsp_valid) begin
            ids[n] = int'(rsp_id);
            check_output("rr_ct", rsp_ciphertext, pt[rsp_id] ^ key[rsp_id][63:0]);
            n++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      check_output("rr_count", n, 5);
      for (int i = 0; i < 5; i++) check_output($sformatf("rr_id%0d", i), ids[i], exp_ids[i]);
      check_output("rr_overlap", overlap, 0);

      // Single job example
      pt[2]  = 64'h0123456789abcdef;
      key[2] = 128'h0000000000000000_00ff00ff00ff00ff;
      run_job("single", 4'b0100, 2, 12);

      // Backpressure: hold rsp_ready low 5 cycles in RESP
      apply_stimulus_random_data();
      wait_grant("bp", 4'b0001, g, t);
      check_output("bp_grant_id", g, 0);
      wait_rsp("bp", t, lat);
      sv_ct = rsp_ciphertext;
      sv_id = rsp_id;
      check_output("bp_ct", sv_ct, pt[0] ^ key[0][63:0]);
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         check_output("bp_valid_held", rsp_valid, 1);
         check_output("bp_id_stable", rsp_id, sv_id);
         check_output("bp_ct_stable", rsp_ciphertext, sv_ct);
         check_output("bp_err_stable", rsp_err, 0);
         check_output("bp_no_ready", req_ready, 0);
         @(negedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      check_output("bp_no_ready_on_hs", req_ready, 0);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check_output("bp_next_grant", req_ready, 4'b0010);
      t = cyc;
      @(negedge clk);
      req_valid = '0;
      wait_rsp("bp2", t, lat);
      check_output("bp2_latency", lat, 12);
      check_output("bp2_rsp_id", rsp_id, 1);
      consume();

      // Spurious done during ISSUE must be ignored
      apply_stimulus_random_data();
      spur_en = 1'b1;
      run_job("spur", 4'b0100, 2, 12);
      spur_en = 1'b0;
      extra = 0;
      for (int k = 0; k < 15; k++) begin
         #1;
         if (rsp_valid) extra++;
         @(negedge clk);
      end
      check_output("spur_extra_rsp", extra, 0);

      // Reset in the middle of WAIT
      apply_stimulus_random_data();
      wait_grant("rstw", 4'b1000, g, t);
      check_output("rstw_grant_id", g, 3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("rstw_rsp_valid", rsp_valid, 0);
      check_output("rstw_core_start", core_start, 0);
      check_output("rstw_rsp_id", rsp_id, 0);
      check_output("rstw_rsp_ct", rsp_ciphertext, 0);
      check_output("rstw_core_pt", core_plaintext, 0);
      check_output("rstw_core_key", core_key, 0);
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) extra++;
      end
      check_output("rstw_no_rsp", extra, 0);
      @(negedge clk);
      run_job("rstw_next", 4'b1010, 1, 12);

      // Table-driven single jobs from a known pointer
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus_random_data();
         run_job($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].exp_id, 12);
      end

      // Randomized traffic against the behavioural model
      apply_reset();
      begin
         logic [N-1:0] pend = '0;
         int exp_ptr = 0;
         int exp_id = 0;
         int t_g = 0;
         int done_jobs = 0;
         bit busy = 1'b0;
         bit seen = 1'b0;
         for (int c = 0; c < 4000 && done_jobs < 40; c++) begin
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && $urandom_range(0, 3) == 0) begin
                  pend[i] = 1'b1;
                  pt[i]   = {$urandom, $urandom};
                  key[i]  = {$urandom, $urandom, $urandom, $urandom};
               end
            end
            req_valid = pend;
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (req_ready != '0) begin
               g = model_pick(pend, exp_ptr);
               check_output("rand_grant", req_ready, 4'b0001 << g);
               check_output("rand_grant_when_idle", busy, 0);
               exp_id = g;
               exp_ct = pt[g] ^ key[g][63:0];
               t_g    = cyc;
               busy   = 1'b1;
               seen   = 1'b0;
               pend[g] = 1'b0;
            end else if (!busy && pend != '0) begin
               check_output("rand_missed_grant", 0, 1);
            end
            if (rsp_valid) begin
               if (!busy) check_output("rand_unexpected_rsp", 1, 0);
               if (!seen) check_output("rand_latency", cyc - t_g, 12);
               seen = 1'b1;
               check_output("rand_rsp_id", rsp_id, exp_id);
               check_output("rand_rsp_ct", rsp_ciphertext, exp_ct);
               if (rsp_ready) begin
                  exp_ptr = (exp_id + 1) % N;
                  busy = 1'b0;
                  done_jobs++;
               end
            end
            @(negedge clk);
         end
         req_valid = '0;
         rsp_ready = 1'b0;
         check_output("rand_jobs_done", done_jobs, 40);
      end

`ifdef ENC_ARB_TIMEOUT_EN
      // Watchdog: no done at all, then done coinciding with expiry
      apply_reset();
      apply_stimulus_random_data();
      stub_never = 1'b1;
      wait_grant("to", 4'b0001, g, t);
      wait_rsp("to", t, lat);
      check_output("to_latency", lat, 22);
      check_output("to_err", rsp_err, 1);
      check_output("to_ct", rsp_ciphertext, 0);
      check_output("to_id", rsp_id, 0);
      consume();
      stub_never = 1'b0;
      stub_lat   = 20;
      run_job("to_tie", 4'b0010, 1, 22);
      stub_lat   = 10;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
